id_ex_pipe_reg: RTL and testbench

ID/EX pipeline register with integrated load-use hazard detection. Captures decoded control, operand data and register indices from the ID stage. Presents registered ID_EX_* fields to the EX stage, the forwarding unit and the EX-stage operand muxes. Inserts a one-cycle bubble on a load-use hazard or on a branch/jump flush, and counts inserted stall cycles.

---
 rtl/id_ex_pipe_reg_if.sv | 61 ++++++
 rtl/id_ex_pipe_reg.sv | 117 +++++++++++
 tb/tb_id_ex_pipe_reg.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_pipe_reg_if.sv
// ID -> EX stage bundle: decoded ID fields in, registered ID_EX_* fields
// plus stall information out. The pipeline register is the slave.
interface id_ex_pipe_reg_if #(
   parameter int WIDTH_SOURCE = 5,
   parameter int DATA_WIDTH   = 32,
   parameter int ALU_CTRL_W   = 4,
   parameter int CNT_W        = 16
);
   // ID stage side
   logic                    Flush;
   logic                    ID_Valid;
   logic                    ID_Uses_Rs1;
   logic                    ID_Uses_Rs2;
   logic [WIDTH_SOURCE-1:0] IF_ID_Rs1;
   logic [WIDTH_SOURCE-1:0] IF_ID_Rs2;
   logic [WIDTH_SOURCE-1:0] IF_ID_Rd;
   logic                    ID_Reg_Wr;
   logic                    ID_Mem_Rd;
   logic                    ID_Mem_Wr;
   logic                    ID_ALU_Src;
   logic [ALU_CTRL_W-1:0]   ID_ALU_Ctrl;
   logic [DATA_WIDTH-1:0]   ID_Rs1_Data;
   logic [DATA_WIDTH-1:0]   ID_Rs2_Data;
   logic [DATA_WIDTH-1:0]   ID_Imm;
   logic [DATA_WIDTH-1:0]   ID_PC;

   // EX stage side
   logic                    ID_EX_Valid;
   logic [WIDTH_SOURCE-1:0] ID_EX_Rs1;
   logic [WIDTH_SOURCE-1:0] ID_EX_Rs2;
   logic [WIDTH_SOURCE-1:0] ID_EX_Rd;
   logic                    ID_EX_Reg_Wr;
   logic                    ID_EX_Mem_Rd;
   logic                    ID_EX_Mem_Wr;
   logic                    ID_EX_ALU_Src;
   logic [ALU_CTRL_W-1:0]   ID_EX_ALU_Ctrl;
   logic [DATA_WIDTH-1:0]   ID_EX_Rs1_Data;
   logic [DATA_WIDTH-1:0]   ID_EX_Rs2_Data;
   logic [DATA_WIDTH-1:0]   ID_EX_Imm;
   logic [DATA_WIDTH-1:0]   ID_EX_PC;
   logic                    Stall;
   logic [CNT_W-1:0]        Stall_Cnt;

   modport master (
      output Flush, ID_Valid, ID_Uses_Rs1, ID_Uses_Rs2, IF_ID_Rs1, IF_ID_Rs2, IF_ID_Rd,
             ID_Reg_Wr, ID_Mem_Rd, ID_Mem_Wr, ID_ALU_Src, ID_ALU_Ctrl,
             ID_Rs1_Data, ID_Rs2_Data, ID_Imm, ID_PC,
      input  ID_EX_Valid, ID_EX_Rs1, ID_EX_Rs2, ID_EX_Rd, ID_EX_Reg_Wr, ID_EX_Mem_Rd,
             ID_EX_Mem_Wr, ID_EX_ALU_Src, ID_EX_ALU_Ctrl, ID_EX_Rs1_Data, ID_EX_Rs2_Data,
             ID_EX_Imm, ID_EX_PC, Stall, Stall_Cnt
   );

   modport slave (
      input  Flush, ID_Valid, ID_Uses_Rs1, ID_Uses_Rs2, IF_ID_Rs1, IF_ID_Rs2, IF_ID_Rd,
             ID_Reg_Wr, ID_Mem_Rd, ID_Mem_Wr, ID_ALU_Src, ID_ALU_Ctrl,
             ID_Rs1_Data, ID_Rs2_Data, ID_Imm, ID_PC,
      output ID_EX_Valid, ID_EX_Rs1, ID_EX_Rs2, ID_EX_Rd, ID_EX_Reg_Wr, ID_EX_Mem_Rd,
             ID_EX_Mem_Wr, ID_EX_ALU_Src, ID_EX_ALU_Ctrl, ID_EX_Rs1_Data, ID_EX_Rs2_Data,
             ID_EX_Imm, ID_EX_PC, Stall, Stall_Cnt
   );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection. A load in EX whose
// rd is read by the valid ID instruction forces a one-cycle bubble and holds
// PC/IF-ID; a flush also bubbles but is not counted as a stall.
module id_ex_pipe_reg #(
   parameter int WIDTH_SOURCE = 5,
   parameter int DATA_WIDTH   = 32,
   parameter int ALU_CTRL_W   = 4,
   parameter int CNT_W        = 16
) (
   input  logic          CLK,
   input  logic          rst,
   id_ex_pipe_reg_if.slave bus
);

   typedef struct packed {
      logic                    valid;
      logic [WIDTH_SOURCE-1:0] rs1;
      logic [WIDTH_SOURCE-1:0] rs2;
      logic [WIDTH_SOURCE-1:0] rd;
      logic                    reg_wr;
      logic                    mem_rd;
      logic                    mem_wr;
      logic                    alu_src;
      logic [ALU_CTRL_W-1:0]   alu_ctrl;
      logic [DATA_WIDTH-1:0]   rs1_data;
      logic [DATA_WIDTH-1:0]   rs2_data;
      logic [DATA_WIDTH-1:0]   imm;
      logic [DATA_WIDTH-1:0]   pc;
   } stage_t;

   stage_t           stage_q, stage_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hazard;
   logic             stall;

   // Load-use detection against the instruction currently held in EX.
   always_comb begin
      hazard = bus.ID_Valid & stage_q.valid & stage_q.mem_rd & (stage_q.rd != '0) &
               ((bus.ID_Uses_Rs1 & (stage_q.rd == bus.IF_ID_Rs1)) |
                (bus.ID_Uses_Rs2 & (stage_q.rd == bus.IF_ID_Rs2)));
      // A flushed ID instruction is discarded anyway, so it needs no stall.
      stall  = hazard & ~bus.Flush;
   end

   // Next-state selection: flush/stall bubble, otherwise load from ID.
   always_comb begin
      // NOTE: every target gets a default first so no path can infer a latch.
      stage_d = stage_q;
      cnt_d   = cnt_q;

      if (bus.Flush || stall) begin
         // Bubble: clear valid, control and indices (rd=x0 never forwards);
         // data fields hold since they are ignored while valid is low.
         stage_d.valid    = 1'b0;
         stage_d.rs1      = '0;
         stage_d.rs2      = '0;
         stage_d.rd       = '0;
         stage_d.reg_wr   = 1'b0;
         stage_d.mem_rd   = 1'b0;
         stage_d.mem_wr   = 1'b0;
         stage_d.alu_src  = 1'b0;
         stage_d.alu_ctrl = '0;
      end else begin
         stage_d.valid    = bus.ID_Valid;
         stage_d.rs1      = bus.IF_ID_Rs1;
         stage_d.rs2      = bus.IF_ID_Rs2;
         stage_d.rd       = bus.IF_ID_Rd;
         // A non-valid slot must never write, read or store.
         stage_d.reg_wr   = bus.ID_Valid & bus.ID_Reg_Wr;
         stage_d.mem_rd   = bus.ID_Valid & bus.ID_Mem_Rd;
         stage_d.mem_wr   = bus.ID_Valid & bus.ID_Mem_Wr;
         stage_d.alu_src  = bus.ID_Valid & bus.ID_ALU_Src;
         stage_d.alu_ctrl = bus.ID_Valid ? bus.ID_ALU_Ctrl : '0;
         stage_d.rs1_data = bus.ID_Rs1_Data;
         stage_d.rs2_data = bus.ID_Rs2_Data;
         stage_d.imm      = bus.ID_Imm;
         stage_d.pc       = bus.ID_PC;
      end

      // Saturating count of load-use bubbles only.
      if (stall && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // State registers with synchronous reset taking priority over everything.
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         // NOTE: data fields are flops, not a memory, so they are reset too
         // and the outputs read all-zero after reset.
         stage_q <= '0;
         cnt_q   <= '0;
      end else begin
         stage_q <= stage_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.ID_EX_Valid    = stage_q.valid;
   assign bus.ID_EX_Rs1      = stage_q.rs1;
   assign bus.ID_EX_Rs2      = stage_q.rs2;
   assign bus.ID_EX_Rd       = stage_q.rd;
   assign bus.ID_EX_Reg_Wr   = stage_q.reg_wr;
   assign bus.ID_EX_Mem_Rd   = stage_q.mem_rd;
   assign bus.ID_EX_Mem_Wr   = stage_q.mem_wr;
   assign bus.ID_EX_ALU_Src  = stage_q.alu_src;
   assign bus.ID_EX_ALU_Ctrl = stage_q.alu_ctrl;
   assign bus.ID_EX_Rs1_Data = stage_q.rs1_data;
   assign bus.ID_EX_Rs2_Data = stage_q.rs2_data;
   assign bus.ID_EX_Imm      = stage_q.imm;
   assign bus.ID_EX_PC       = stage_q.pc;
   assign bus.Stall          = stall;
   assign bus.Stall_Cnt      = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: the driver predicts each cycle's
// Stall and the post-edge register contents; a monitor compares them.
module tb_id_ex_pipe_reg;

   localparam int WS = 5;
   localparam int DW = 32;
   localparam int AW = 4;
   localparam int CW = 2;
   localparam int CNT_MAX = (1 << CW) - 1;

   typedef struct packed {
      logic          valid;
      logic          uses1;
      logic          uses2;
      logic [WS-1:0] rs1;
      logic [WS-1:0] rs2;
      logic [WS-1:0] rd;
      logic          reg_wr;
      logic          mem_rd;
      logic          mem_wr;
      logic          alu_src;
      logic [AW-1:0] alu_ctrl;
      logic [DW-1:0] d1;
      logic [DW-1:0] d2;
      logic [DW-1:0] imm;
      logic [DW-1:0] pc;
   } id_t;

   typedef struct packed {
      logic          valid;
      logic [WS-1:0] rs1;
      logic [WS-1:0] rs2;
      logic [WS-1:0] rd;
      logic          reg_wr;
      logic          mem_rd;
      logic          mem_wr;
      logic          alu_src;
      logic [AW-1:0] alu_ctrl;
      logic [DW-1:0] d1;
      logic [DW-1:0] d2;
      logic [DW-1:0] imm;
      logic [DW-1:0] pc;
      logic [CW-1:0] cnt;
   } ex_t;

   typedef struct packed {
      logic stall;
      ex_t  regs;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   id_ex_pipe_reg_if #(.WIDTH_SOURCE(WS), .DATA_WIDTH(DW), .ALU_CTRL_W(AW), .CNT_W(CW)) bus ();

   id_ex_pipe_reg #(.WIDTH_SOURCE(WS), .DATA_WIDTH(DW), .ALU_CTRL_W(AW), .CNT_W(CW)) dut (
      .CLK (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   exp_t exp_q[$];
   ex_t  model = '0;
   int   stall_total = 0;
   int   checks = 0;
   int   failures = 0;

   function automatic id_t rand_id();
      id_t r;
      r.valid    = ($urandom_range(0, 7) != 0);
      r.uses1    = 1'($urandom_range(0, 1));
      r.uses2    = 1'($urandom_range(0, 1));
      r.rs1      = WS'($urandom_range(0, 3));
      r.rs2      = WS'($urandom_range(0, 3));
      r.rd       = WS'($urandom_range(0, 3));
      r.reg_wr   = 1'($urandom_range(0, 1));
      r.mem_rd   = 1'($urandom_range(0, 1));
      r.mem_wr   = 1'($urandom_range(0, 1));
      r.alu_src  = 1'($urandom_range(0, 1));
      r.alu_ctrl = AW'($urandom_range(0, 15));
      r.d1       = $urandom;
      r.d2       = $urandom;
      r.imm      = $urandom;
      r.pc       = $urandom;
      return r;
   endfunction

   // A quiet valid instruction (no load, no sources) with random payload.
   function automatic id_t plain_id();
      id_t r = rand_id();
      r.valid  = 1'b1;
      r.uses1  = 1'b0;
      r.uses2  = 1'b0;
      r.mem_rd = 1'b0;
      return r;
   endfunction

   function automatic id_t load_id(input logic [WS-1:0] rd);
      id_t r = plain_id();
      r.mem_rd = 1'b1;
      r.reg_wr = 1'b1;
      r.rd     = rd;
      return r;
   endfunction

   // Drive one cycle's ID inputs at the falling edge and predict the result.
   task automatic cycle(input id_t in, input logic fl, input logic r, output logic stall_o);
      logic haz;
      exp_t e;
      @(negedge clk);
      rst                 = r;
      bus.Flush           = fl;
      bus.ID_Valid        = in.valid;
      bus.ID_Uses_Rs1     = in.uses1;
      bus.ID_Uses_Rs2     = in.uses2;
      bus.IF_ID_Rs1       = in.rs1;
      bus.IF_ID_Rs2       = in.rs2;
      bus.IF_ID_Rd        = in.rd;
      bus.ID_Reg_Wr       = in.reg_wr;
      bus.ID_Mem_Rd       = in.mem_rd;
      bus.ID_Mem_Wr       = in.mem_wr;
      bus.ID_ALU_Src      = in.alu_src;
      bus.ID_ALU_Ctrl     = in.alu_ctrl;
      bus.ID_Rs1_Data     = in.d1;
      bus.ID_Rs2_Data     = in.d2;
      bus.ID_Imm          = in.imm;
      bus.ID_PC           = in.pc;

      haz = in.valid && model.valid && model.mem_rd && (model.rd != 0) &&
            ((in.uses1 && model.rd == in.rs1) || (in.uses2 && model.rd == in.rs2));
      stall_o = haz && !fl;
      e.stall = stall_o;

      if (r) begin
         model       = '0;
         stall_total = 0;
      end else begin
         if (stall_o) stall_total++;
         model.cnt = CW'((stall_total > CNT_MAX) ? CNT_MAX : stall_total);
         if (fl || stall_o) begin
            model.valid = 0; model.rs1 = 0; model.rs2 = 0; model.rd = 0;
            model.reg_wr = 0; model.mem_rd = 0; model.mem_wr = 0;
            model.alu_src = 0; model.alu_ctrl = 0;
         end else begin
            model.valid    = in.valid;
            model.rs1      = in.rs1;
            model.rs2      = in.rs2;
            model.rd       = in.rd;
            model.reg_wr   = in.valid && in.reg_wr;
            model.mem_rd   = in.valid && in.mem_rd;
            model.mem_wr   = in.valid && in.mem_wr;
            model.alu_src  = in.valid && in.alu_src;
            model.alu_ctrl = in.valid ? in.alu_ctrl : '0;
            model.d1       = in.d1;
            model.d2       = in.d2;
            model.imm      = in.imm;
            model.pc       = in.pc;
         end
      end
      e.regs = model;
      exp_q.push_back(e);
   endtask

   // Monitor: Stall is sampled late in the low phase, registers just after the edge.
   initial begin
      logic st_s;
      ex_t  act;
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         st_s = bus.Stall;
         @(posedge clk);
         #1;
         act = '{bus.ID_EX_Valid, bus.ID_EX_Rs1, bus.ID_EX_Rs2, bus.ID_EX_Rd, bus.ID_EX_Reg_Wr,
                 bus.ID_EX_Mem_Rd, bus.ID_EX_Mem_Wr, bus.ID_EX_ALU_Src, bus.ID_EX_ALU_Ctrl,
                 bus.ID_EX_Rs1_Data, bus.ID_EX_Rs2_Data, bus.ID_EX_Imm, bus.ID_EX_PC,
                 bus.Stall_Cnt};
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (st_s !== e.stall) begin
               failures++;
               $display("FAIL stall @%0t: got %b expected %b", $time, st_s, e.stall);
            end
            checks++;
            if (act !== e.regs) begin
               failures++;
               $display("FAIL regs @%0t: got %h expected %h", $time, act, e.regs);
            end
         end
      end
   end

   initial begin
      #100000;
      failures++;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      logic st;
      id_t  cur, ld, cons;

      bus.Flush = 0; bus.ID_Valid = 0; bus.ID_Uses_Rs1 = 0; bus.ID_Uses_Rs2 = 0;
      bus.IF_ID_Rs1 = 0; bus.IF_ID_Rs2 = 0; bus.IF_ID_Rd = 0; bus.ID_Reg_Wr = 0;
      bus.ID_Mem_Rd = 0; bus.ID_Mem_Wr = 0; bus.ID_ALU_Src = 0; bus.ID_ALU_Ctrl = 0;
      bus.ID_Rs1_Data = 0; bus.ID_Rs2_Data = 0; bus.ID_Imm = 0; bus.ID_PC = 0;

      // Reset held for two cycles with random ID traffic.
      repeat (2) cycle(rand_id(), 1'b0, 1'b1, st);

      // Pass-through.
      cur = plain_id();
      cur.rs1 = 3; cur.rs2 = 4; cur.rd = 5; cur.reg_wr = 1; cur.mem_wr = 0; cur.alu_src = 0;
      cur.alu_ctrl = 4'h2; cur.imm = 32'h10; cur.pc = 32'h100; cur.uses1 = 1; cur.uses2 = 1;
      cycle(cur, 1'b0, 1'b0, st);

      // Load-use on rs2: stall once, then the held instruction loads.
      ld = load_id(7);
      cons = plain_id(); cons.uses2 = 1; cons.rs2 = 7; cons.rs1 = 1;
      cycle(ld, 1'b0, 1'b0, st);
      cycle(cons, 1'b0, 1'b0, st);
      cycle(cons, 1'b0, 1'b0, st);

      // No false stall: rd=x0, unused sources, non-valid ID slot.
      cycle(load_id(0), 1'b0, 1'b0, st);
      cons = plain_id(); cons.uses1 = 1; cons.uses2 = 1; cons.rs1 = 0; cons.rs2 = 0;
      cycle(cons, 1'b0, 1'b0, st);
      cycle(ld, 1'b0, 1'b0, st);
      cons = plain_id(); cons.rs1 = 7; cons.rs2 = 7;
      cycle(cons, 1'b0, 1'b0, st);
      cycle(ld, 1'b0, 1'b0, st);
      cons.valid = 0; cons.uses1 = 1; cons.uses2 = 1;
      cycle(cons, 1'b0, 1'b0, st);

      // Flush wins over a hazard: bubble, no stall, count unchanged.
      cycle(ld, 1'b0, 1'b0, st);
      cons = plain_id(); cons.uses1 = 1; cons.rs1 = 7;
      cycle(cons, 1'b1, 1'b0, st);
      cycle(plain_id(), 1'b0, 1'b0, st);

      // Five load-use stalls drive the 2-bit counter into saturation.
      repeat (5) begin
         cycle(ld, 1'b0, 1'b0, st);
         cycle(cons, 1'b0, 1'b0, st);
         cycle(cons, 1'b0, 1'b0, st);
      end

      // Reset together with flush and a live hazard.
      cycle(ld, 1'b0, 1'b0, st);
      cycle(cons, 1'b1, 1'b1, st);
      cycle(plain_id(), 1'b0, 1'b0, st);

      // Random traffic; a stalled instruction is re-presented like a held IF/ID.
      cur = rand_id();
      repeat (400) begin
         cycle(cur, 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 59) == 0), st);
         if (!st) cur = rand_id();
      end

      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
